adsr_envelope: RTL

ADSR_ENVELOPE -- requirements
Module: adsr_envelope

---
 rtl/adsr_pkg.sv | 15 +
 rtl/adsr_step_sat.sv | 38 +++
 rtl/adsr_envelope.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/adsr_pkg.sv
// Shared definitions for the ADSR envelope generator: state codes and width defaults.
package adsr_pkg;

  localparam int ENV_W_DEF = 16;
  localparam logic [ENV_W_DEF-1:0] ENV_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

endpackage

// File: rtl/adsr_step_sat.sv
// Saturating add/subtract against a limit: adds clamp up to limit, subtracts clamp down to it.
module adsr_step_sat #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic [W-1:0] limit,
  output logic [W-1:0] result,
  output logic         hit
);

  logic [W:0]   w_sum;
  logic [W:0]   w_lim_plus_b;
  logic [W-1:0] w_diff;
  logic         w_add_hit;
  logic         w_sub_hit;

  assign w_sum        = {1'b0, a} + {1'b0, b};
  assign w_lim_plus_b = {1'b0, limit} + {1'b0, b};
  // a - b <= limit, evaluated without borrow; also catches a already below limit.
  assign w_sub_hit    = ({1'b0, a} <= w_lim_plus_b);
  assign w_add_hit    = (w_sum >= {1'b0, limit});
  assign w_diff       = a - b;

  always_comb begin
    hit    = 1'b0;
    result = a;
    if (sub) begin
      hit    = w_sub_hit;
      result = w_sub_hit ? limit : w_diff;
    end else begin
      hit    = w_add_hit;
      result = w_add_hit ? limit : w_sum[W-1:0];
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator; all arithmetic and transitions advance on tick strobes.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int ENV_W = ENV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             gate,
  input  logic [ENV_W-1:0] attack_step,
  input  logic [ENV_W-1:0] decay_step,
  input  logic [7:0]       sustain_level,
  input  logic [ENV_W-1:0] release_step,
  output logic [ENV_W-1:0] env,
  output logic [2:0]       state,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  logic [ENV_W-1:0] r_env;
  logic             r_done;

  state_e           w_next_state;
  logic [ENV_W-1:0] w_next_env;
  logic             w_next_done;

  logic [ENV_W-1:0] w_max;
  logic [ENV_W-1:0] w_target;
  logic [ENV_W-1:0] w_sat_b;
  logic             w_sat_sub;
  logic [ENV_W-1:0] w_sat_limit;
  logic [ENV_W-1:0] w_sat_result;
  logic             w_sat_hit;

  assign w_max = {ENV_W{1'b1}};

  // Sustain level repeated from the MSB downwards to fill the envelope width.
  for (genvar g = 0; g < ENV_W; g++) begin : g_target
    assign w_target[ENV_W-1-g] = sustain_level[7-(g%8)];
  end

  always_comb begin
    w_sat_b     = attack_step;
    w_sat_sub   = 1'b0;
    w_sat_limit = w_max;
    case (r_state)
      ST_DECAY: begin
        w_sat_b     = decay_step;
        w_sat_sub   = 1'b1;
        w_sat_limit = w_target;
      end
      ST_RELEASE: begin
        w_sat_b     = release_step;
        w_sat_sub   = 1'b1;
        w_sat_limit = '0;
      end
      default: begin
        w_sat_b     = attack_step;
        w_sat_sub   = 1'b0;
        w_sat_limit = w_max;
      end
    endcase
  end

  adsr_step_sat #(.W(ENV_W)) u_step_sat (
    .a      (r_env),
    .b      (w_sat_b),
    .sub    (w_sat_sub),
    .limit  (w_sat_limit),
    .result (w_sat_result),
    .hit    (w_sat_hit)
  );

  // Gate-driven transitions take precedence and leave env untouched on that tick.
  always_comb begin
    w_next_state = r_state;
    w_next_env   = r_env;
    w_next_done  = 1'b0;
    if (tick) begin
      case (r_state)
        ST_IDLE: begin
          if (gate) w_next_state = ST_ATTACK;
          else      w_next_env   = '0;
        end
        ST_ATTACK: begin
          if (!gate) begin
            w_next_state = ST_RELEASE;
          end else begin
            w_next_env = w_sat_result;
            if (w_sat_hit) w_next_state = ST_DECAY;
          end
        end
        ST_DECAY: begin
          if (!gate) begin
            w_next_state = ST_RELEASE;
          end else begin
            w_next_env = w_sat_result;
            if (w_sat_hit) w_next_state = ST_SUSTAIN;
          end
        end
        ST_SUSTAIN: begin
          if (!gate) w_next_state = ST_RELEASE;
          else       w_next_env   = w_target;
        end
        ST_RELEASE: begin
          if (gate) begin
            w_next_state = ST_ATTACK;
          end else begin
            w_next_env = w_sat_result;
            if (w_sat_hit) begin
              w_next_state = ST_IDLE;
              w_next_done  = 1'b1;
            end
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_next_env   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_env   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_env   <= w_next_env;
      r_done  <= w_next_done;
    end
  end

  assign env   = r_env;
  assign state = r_state;
  assign busy  = (r_state != ST_IDLE);
  assign done  = r_done;

endmodule
